// File: rtl/rock_driver.sv
// Cradle actuator driver: turns latched amplitude/frequency levels into a
// triangular swing (position, direction, PWM) that only retunes at the rest point.
module rock_driver #(
  parameter int PRESCALE = 48000,
  parameter int AMP_UNIT = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] A,
  input  logic [2:0] F,
  output logic [7:0] pos,
  output logic       dir,
  output logic       pwm,
  output logic       cycle_done,
  output logic       range_err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;

  state_t        state;
  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [7:0]    pwm_cnt;
  logic [2:0]    a_l, f_l;
  logic [2:0]    a_new, f_new;
  logic          a_bad, f_bad;
  logic          go;
  logic [7:0]    limit;
  logic [8:0]    sum;

  assign tick  = (ps_cnt == PS_MAX);

  // Out-of-range levels are clamped to the strongest legal level.
  assign a_bad = (A > 3'd4);
  assign f_bad = (F > 3'd4);
  assign a_new = a_bad ? 3'd4 : A;
  assign f_new = f_bad ? 3'd4 : F;
  assign go    = (a_new != 3'd0) && (f_new != 3'd0);

  assign limit = 8'(AMP_UNIT) * {5'd0, a_l};
  // Nine bits so the peak test cannot be fooled by a wrap.
  assign sum   = {1'b0, pos} + {6'd0, f_l};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let later statements see new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= 8'd0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm     <= (pwm_cnt < pos);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pos        <= 8'd0;
      dir        <= 1'b0;
      cycle_done <= 1'b0;
      range_err  <= 1'b0;
      a_l        <= 3'd0;
      f_l        <= 3'd0;
    end else begin
      cycle_done <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            a_l <= a_new;
            f_l <= f_new;
            if (a_bad || f_bad) range_err <= 1'b1;
            if (go) begin
              state <= RISE;
              dir   <= 1'b0;
            end
          end
          RISE: begin
            if (sum >= {1'b0, limit}) begin
              pos   <= limit;
              dir   <= 1'b1;
              state <= FALL;
            end else begin
              pos <= sum[7:0];
            end
          end
          FALL: begin
            if (pos <= {5'd0, f_l}) begin
              // Rest point: the only place mid-run level changes are picked up.
              pos        <= 8'd0;
              dir        <= 1'b0;
              cycle_done <= 1'b1;
              a_l        <= a_new;
              f_l        <= f_new;
              if (a_bad || f_bad) range_err <= 1'b1;
              state      <= go ? RISE : IDLE;
            end else begin
              pos <= pos - {5'd0, f_l};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rock_driver.sv
// Self-checking bench for rock_driver: tick-by-tick vector tables fed through a
// scoreboard queue, plus hand-written reset, stop and PWM-duty sequences.
module tb_rock_driver;

  typedef struct {
    logic [2:0] a;
    logic [2:0] f;
    logic [7:0] pos;
    logic       dir;
    logic       done;
    logic       err;
    logic       chk_pwm;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] a = 3'd0, f = 3'd0;
  logic [7:0] pos;
  logic       dir, pwm, cycle_done, range_err;

  logic       reset6 = 1'b1;
  logic [2:0] a6 = 3'd2, f6 = 3'd3;
  logic [7:0] pos6;
  logic       dir6, pwm6, done6, err6;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;
  int wide_cnt  = 0;
  int pwm_hi_cnt = 0;
  logic done_prev = 1'b0;

  vec_t sb[$];

  rock_driver #(.PRESCALE(4), .AMP_UNIT(10)) dut (
    .clk(clk), .reset(reset), .A(a), .F(f), .pos(pos), .dir(dir),
    .pwm(pwm), .cycle_done(cycle_done), .range_err(range_err)
  );

  rock_driver #(.PRESCALE(600), .AMP_UNIT(10)) dut6 (
    .clk(clk), .reset(reset6), .A(a6), .F(f6), .pos(pos6), .dir(dir6),
    .pwm(pwm6), .cycle_done(done6), .range_err(err6)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cycle_done) pulse_cnt++;
    if (cycle_done && done_prev) wide_cnt++;
    if (pwm) pwm_hi_cnt++;
    done_prev = cycle_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_pos", 32'(pos), 0);
    check("reset_dir", 32'(dir), 0);
    check("reset_pwm", 32'(pwm), 0);
    check("reset_done", 32'(cycle_done), 0);
    check("reset_err", 32'(range_err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one tick's inputs, queue its expectation, then compare after the update edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    a = v.a;
    f = v.f;
    sb.push_back(v);
    repeat (4) @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, "_pos"}, 32'(pos), 32'(e.pos));
    check({tag, "_dir"}, 32'(dir), 32'(e.dir));
    check({tag, "_done"}, 32'(cycle_done), 32'(e.done));
    check({tag, "_err"}, 32'(range_err), 32'(e.err));
    if (e.chk_pwm) check({tag, "_pwm"}, 32'(pwm), 0);
  endtask

  function automatic vec_t mk(int av, int fv, int p, int d, int dn, int er);
    vec_t v;
    v.a = 3'(av); v.f = 3'(fv); v.pos = 8'(p);
    v.dir = 1'(d); v.done = 1'(dn); v.err = 1'(er); v.chk_pwm = 1'b0;
    return v;
  endfunction

  vec_t s1[16];
  int   p1[16] = '{0, 3, 6, 9, 12, 15, 18, 20, 17, 14, 11, 8, 5, 2, 0, 3};

  task automatic run_s1(input string tag);
    for (int i = 0; i < 16; i++) apply(s1[i], $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    int snap_p, snap_h, budget, hi;
    vec_t v;

    for (int i = 0; i < 16; i++)
      s1[i] = mk(2, 3, p1[i], (i >= 7 && i <= 13) ? 1 : 0, (i == 14) ? 1 : 0, 0);

    a = 3'd2; f = 3'd3;
    #1;
    check("reset_pos_init", 32'(pos), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    reset6 = 1'b0;

    // Basic swing, then back-to-back start of the next swing.
    run_s1("s1");

    // Mid-swing change from 4/4 to 1/1 takes effect only after the rest point.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      int av, fv, p, d, dn;
      av = (k < 4) ? 4 : 1;
      fv = av;
      if (k <= 10)      p = 4 * k;
      else if (k <= 20) p = 40 - 4 * (k - 10);
      else              p = k - 20;
      d  = ((k >= 10 && k <= 19) || k >= 30) ? 1 : 0;
      dn = (k == 20) ? 1 : 0;
      if (k == 31) begin p = 9; d = 1; end
      apply(mk(av, fv, p, d, dn, 0), $sformatf("s2[%0d]", k));
    end

    // Stop request mid-swing: swing completes, IDLE holds, F=2 restarts.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      v = s1[i];
      if (i >= 3) v.f = 3'd0;
      apply(v, $sformatf("s3[%0d]", i));
    end
    apply(mk(2, 0, 0, 0, 0, 0), "s3_idle0");
    snap_p = pulse_cnt;
    snap_h = pwm_hi_cnt;
    v = mk(2, 0, 0, 0, 0, 0); v.chk_pwm = 1'b1;
    apply(v, "s3_idle1");
    v = mk(2, 2, 0, 0, 0, 0); v.chk_pwm = 1'b1;
    apply(v, "s3_relatch");
    check("s3_idle_pulses", 32'(pulse_cnt - snap_p), 0);
    check("s3_idle_pwm_high", 32'(pwm_hi_cnt - snap_h), 0);
    apply(mk(2, 2, 2, 0, 0, 0), "s3_restart0");
    apply(mk(2, 2, 4, 0, 0, 0), "s3_restart1");

    // Out-of-range levels clamp to 4/4 and the error flag sticks.
    do_reset();
    for (int k = 0; k < 22; k++) begin
      int p, d;
      if (k <= 10)      p = 4 * k;
      else if (k <= 20) p = 40 - 4 * (k - 10);
      else              p = 3;
      d = (k >= 10 && k <= 19) ? 1 : 0;
      apply(mk((k <= 10) ? 7 : 2, (k <= 10) ? 6 : 3, p, d, (k == 20) ? 1 : 0, 1),
            $sformatf("s4[%0d]", k));
    end

    // Reset asserted mid-fall at pos=25, then the basic timing again.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      int p;
      if (k <= 13)      p = 3 * k;
      else if (k == 14) p = 40;
      else              p = 40 - 3 * (k - 14);
      apply(mk(4, 3, p, (k >= 14) ? 1 : 0, 0, 0), $sformatf("s5[%0d]", k));
    end
    snap_p = pulse_cnt;
    a = 3'd2; f = 3'd3;
    do_reset();
    check("s5_no_done_on_reset", 32'(pulse_cnt - snap_p), 0);
    run_s1("s5_after");

    check("done_width_one_clock", 32'(wide_cnt), 0);

    // PWM duty at a held peak on the slow instance.
    budget = 0;
    while (pos6 !== 8'd20 && budget < 20000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("s6_reach_peak", 32'(pos6), 20);
    check("s6_dir_at_peak", 32'(dir6), 1);
    repeat (2) @(posedge clk);
    #1;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm6) hi++;
      @(posedge clk);
      #1;
    end
    check("s6_duty", 32'(hi), 20);
    check("s6_pos_held", 32'(pos6), 20);
    check("s6_done_low", 32'(done6), 0);
    check("s6_err_low", 32'(err6), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
